traffic_intersection_ctrl: RTL

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

---
 rtl/traffic_intersection_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_intersection_ctrl                                                |
// | Round-robin intersection signal controller with pedestrian walk phase.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module traffic_intersection_ctrl #(
  parameter int NUM_DIR     = 4,
  parameter int GREEN_MIN   = 6,
  parameter int GREEN_MAX   = 12,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_DIR-1:0]     car_sensor,
  input  logic [NUM_DIR-1:0]     pedestrian_button,
  output logic [3*NUM_DIR-1:0]   lights,
  output logic [NUM_DIR-1:0]     walk,
  output logic [1:0]             active_dir,
  output logic [1:0]             phase
);

  localparam int c_CNT_W = $clog2(GREEN_MAX + YELLOW_TIME + ALLRED_TIME + WALK_TIME + 1);
  localparam logic [c_CNT_W-1:0] c_GMIN_END  = c_CNT_W'(GREEN_MIN - 1);
  localparam logic [c_CNT_W-1:0] c_GMAX_END  = c_CNT_W'(GREEN_MAX - 1);
  localparam logic [c_CNT_W-1:0] c_YEL_END   = c_CNT_W'(YELLOW_TIME - 1);
  localparam logic [c_CNT_W-1:0] c_AR_END    = c_CNT_W'(ALLRED_TIME - 1);
  localparam logic [c_CNT_W-1:0] c_WALK_END  = c_CNT_W'(WALK_TIME - 1);
  localparam logic [2:0]         c_RED       = 3'b001;
  localparam logic [2:0]         c_YELLOW    = 3'b010;
  localparam logic [2:0]         c_GREEN     = 3'b100;

  typedef enum logic [1:0] {
    S_GREEN  = 2'b00,
    S_YELLOW = 2'b01,
    S_ALLRED = 2'b10,
    S_WALK   = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_count;
  logic [1:0]           r_active_dir;
  logic [1:0]           w_dir_nxt;
  logic [NUM_DIR-1:0]   r_ped_pending;
  logic [NUM_DIR-1:0]   r_walk_mask;
  logic                 w_walk_entry;
  logic                 w_demand;
  logic                 w_found;
  logic [1:0]           w_sel_dir;

  // First waiting approach after the current one; plain successor if nobody waits.
  always_comb begin
    w_found   = 1'b0;
    w_sel_dir = 2'((int'(r_active_dir) + 1) % NUM_DIR);
    for (int k = 1; k <= NUM_DIR; k++) begin
      for (int i = 0; i < NUM_DIR; i++) begin
        if (!w_found && (i == (int'(r_active_dir) + k) % NUM_DIR) && car_sensor[i]) begin
          w_found   = 1'b1;
          w_sel_dir = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_demand = |r_ped_pending;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (car_sensor[i] && (2'(i) != r_active_dir)) begin
        w_demand = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_nxt    = r_active_dir;
    w_walk_entry = 1'b0;
    case (r_state)
      S_GREEN: begin
        if ((r_count == c_GMAX_END) || ((r_count >= c_GMIN_END) && w_demand)) begin
          w_state_nxt = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (r_count == c_YEL_END) begin
          w_state_nxt = S_ALLRED;
        end
      end
      S_ALLRED: begin
        if (r_count == c_AR_END) begin
          if (|r_ped_pending) begin
            w_state_nxt  = S_WALK;
            w_walk_entry = 1'b1;
          end else begin
            w_state_nxt = S_GREEN;
            w_dir_nxt   = w_sel_dir;
          end
        end
      end
      default: begin
        if (r_count == c_WALK_END) begin
          w_state_nxt = S_GREEN;
          w_dir_nxt   = w_sel_dir;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_ALLRED;
      r_count       <= '0;
      r_active_dir  <= 2'(NUM_DIR - 1);
      r_ped_pending <= '0;
      r_walk_mask   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= (w_state_nxt != r_state) ? '0 : r_count + c_CNT_W'(1);
      r_active_dir <= w_dir_nxt;
      // A press landing on the walk-entry cycle survives for the following walk.
      if (w_walk_entry) begin
        r_walk_mask   <= r_ped_pending;
        r_ped_pending <= pedestrian_button;
      end else begin
        r_ped_pending <= r_ped_pending | pedestrian_button;
      end
    end
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      lights[3*i +: 3] = c_RED;
      if (2'(i) == r_active_dir) begin
        if (r_state == S_GREEN) begin
          lights[3*i +: 3] = c_GREEN;
        end else if (r_state == S_YELLOW) begin
          lights[3*i +: 3] = c_YELLOW;
        end
      end
    end
  end

  assign walk       = (r_state == S_WALK) ? r_walk_mask : '0;
  assign active_dir = r_active_dir;
  assign phase      = r_state;

endmodule
`default_nettype wire
